// File: rtl/fp32_acc_seq.sv
// fp32_acc_seq: feeds a counted FP32 valid/ready stream into an o1adder-style unit and reports the sum.
// Optional macro FP32_ACC_SEQ_ABORT_EN adds an abort input that cancels a run in LOAD/ACC.
//
// state | meaning
// IDLE  | waiting for start; adder holds its output (ctrl 100)
// LOAD  | first element loads the adder (ctrl 010)
// ACC   | further elements accumulate into the adder (ctrl 001)
// FLUSH | adder out holds the final sum; captured into res_data
module fp32_acc_seq #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef FP32_ACC_SEQ_ABORT_EN
  input  logic             abort,
`endif
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             in_valid,
  input  logic [31:0]      in_data,
  output logic             in_ready,
  output logic [31:0]      add_ain,
  output logic [31:0]      add_bin,
  output logic [2:0]       add_ctrl,
  input  logic [31:0]      add_out,
  output logic             res_valid,
  output logic [31:0]      res_data,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_ACC,
    S_FLUSH
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] rem_q;
  logic             res_valid_q;
  logic [31:0]      res_data_q;

  logic active;
  logic abort_c;
  logic take;

  assign active = (state_q == S_LOAD) || (state_q == S_ACC);

`ifdef FP32_ACC_SEQ_ABORT_EN
  assign abort_c = abort && active;
`else
  assign abort_c = 1'b0;
`endif

  assign in_ready  = active && !abort_c;
  assign take      = in_valid && in_ready;
  assign busy      = (state_q != S_IDLE);
  assign add_ain   = add_out;
  assign add_bin   = in_data;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;

  // Hold (100) is the resting command so the adder keeps its running value across bubbles.
  always_comb begin
    add_ctrl = 3'b100;
    case (state_q)
      S_IDLE: begin
        if (start && (len == '0)) add_ctrl = 3'b000;
      end
      S_LOAD: begin
        if (abort_c)   add_ctrl = 3'b000;
        else if (take) add_ctrl = 3'b010;
      end
      S_ACC: begin
        if (abort_c)   add_ctrl = 3'b000;
        else if (take) add_ctrl = 3'b001;
      end
      default: add_ctrl = 3'b100;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rem_q       <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
    end else begin
      res_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (len == '0) begin
              state_q <= S_FLUSH;
            end else begin
              rem_q   <= len;
              state_q <= S_LOAD;
            end
          end
        end
        S_LOAD, S_ACC: begin
          if (abort_c) begin
            rem_q   <= '0;
            state_q <= S_IDLE;
          end else if (take) begin
            rem_q   <= rem_q - CNT_W'(1);
            state_q <= (rem_q == CNT_W'(1)) ? S_FLUSH : S_ACC;
          end
        end
        S_FLUSH: begin
          res_data_q  <= add_out;
          res_valid_q <= 1'b1;
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/fp32_acc_seq.md
Name: fp32_acc_seq

Overview:
- Sequencer on the initiator side of an o1adder-style unit: FP32 adder with a one-hot 3-bit output select (bit2 pass ain, bit1 pass bin, bit0 pass sum; 000 yields 0) and a 1-cycle registered result.
- Accepts a start command with an element count, consumes a valid/ready FP32 stream and drives the unit's ain/bin/ctrl.
- Feeds the unit's registered out back as the running sum and emits the final accumulated value as a one-cycle result pulse.
- Sits between a stream producer (e.g. a row reader) and the adder datapath.

Parameters:
- CNT_W, 8, width of the element-count field; max length 2^CNT_W-1.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin a new accumulation; sampled only in IDLE.
- len  input  CNT_W  element count, sampled with start.
- in_valid  input  1  stream element valid.
- in_data  input  32  FP32 stream element.
- in_ready  output  1  sequencer accepts in_data this cycle.
- add_ain  output  32  to adder unit ain.
- add_bin  output  32  to adder unit bin.
- add_ctrl  output  3  to adder unit ctrl, one-hot or 000.
- add_out  input  32  registered result from adder unit; 1-cycle latency.
- res_valid  output  1  one-cycle pulse; res_data holds the final sum.
- res_data  output  32  final sum; held until the next result.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset: state=IDLE, remaining count=0, res_valid=0, res_data=0.
- Combinational outputs driven from state during reset:
  - busy=0, in_ready=0.
  - add_ctrl=100, add_ain=add_out, add_bin=in_data.
- add_ain is always add_out, so the feedback path is add_out -> adder -> out register. add_bin is always in_data.
- States: IDLE, LOAD, ACC, FLUSH.
- IDLE:
  - in_ready=0, add_ctrl=100 (hold).
  - start && len==0: add_ctrl=000 this cycle, go FLUSH, so the result is +0 (0x00000000).
  - start && len!=0: remaining<=len, go LOAD.
- LOAD:
  - in_ready=1.
  - On in_valid: add_ctrl=010 (load in_data), remaining<=remaining-1. Go FLUSH if remaining==1, else ACC.
  - No in_valid: add_ctrl=100.
- ACC:
  - in_ready=1.
  - On in_valid: add_ctrl=001 (sum = add_out + in_data), remaining<=remaining-1. Go FLUSH if remaining==1.
  - No in_valid: add_ctrl=100 (hold the running sum, no bubble error).
- FLUSH:
  - in_ready=0, add_ctrl=100.
  - add_out now holds the final value; res_data<=add_out, res_valid<=1 at the edge; go IDLE.
- res_valid is high exactly one cycle (the first IDLE cycle after FLUSH); deasserts the next cycle.
- Throughput: one element per cycle while in_valid stays high.
- Latency: element accepted at cycle t with remaining==1 -> FLUSH at t+1 -> res_valid at t+2.
- start while busy: ignored.
- start in the same cycle res_valid is high: accepted normally.
- len is captured only at start; later changes are ignored.
- Element handshake = in_valid && in_ready; no element is consumed in IDLE or FLUSH.
- Async reset mid-operation: immediate return to reset values, no res_valid. The adder unit is reset by the same rst_n.
- The sequencer performs no FP arithmetic; NaN/Inf propagate as the adder produces them.

Optional Feature:
- Macro FP32_ACC_SEQ_ABORT_EN.
- Defined:
  - Adds input port abort (1 bit).
  - abort high in LOAD or ACC: in_ready=0 that cycle, add_ctrl=000, next state IDLE, remaining<=0, no res_valid; res_data keeps its old value.
  - abort has priority over in_valid.
  - abort in IDLE or FLUSH: ignored.
- Not defined: port absent; behaviour as above.

Test Plan:
- Reset, then start len=3 with stream 1.0(3F800000), 2.0(40000000), 3.0(40400000) back-to-back -> add_ctrl sequence 010,001,001,100; res_valid pulse 2 cycles after the last accept; res_data=40C00000.
- Same stream with in_valid low for 2 cycles between elements 2 and 3 -> add_ctrl=100 in the gaps, add_out held at 40400000; res_data=40C00000.
- start len=0 -> add_ctrl=000, then FLUSH; res_valid one cycle with res_data=00000000; in_ready never high.
- start len=1 with 2.0 -> res_data=40000000. Pulse start again during busy -> ignored. Start on the res_valid cycle -> new run begins.
- Assert rst_n low mid-ACC after 2 of 4 elements -> busy=0, in_ready=0, res_valid=0, res_data=0 immediately. A new start len=2 with 1.0,1.0 -> res_data=40000000.
- FP32_ACC_SEQ_ABORT_EN: abort after 1 of 3 elements -> IDLE next cycle, no res_valid, prior res_data unchanged. A following len=1 run with 3.0 -> res_data=40400000.
